// File: rtl/aes_inv_cipher_iter.sv
// rtl/aes_inv_cipher_iter.sv - iterative AES-128 inverse cipher, one inverse round per clock
// Optional feature macro: AES_INV_KEY_LATCH_EN (capture the key schedule on accept)
module aes_inv_cipher_iter (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [0:127]  i_cipher_text,
  input  logic [0:1407] i_key_schedule,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [0:127]  o_plain_text,
  output logic          o_busy
);

  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    rnd;
  logic [0:127]  st;
  logic [0:1407] ks;
  logic [0:127]  rk;
  logic [0:127]  add_rk;
  logic [0:127]  mix_out;

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [0:31] inv_mix_col(input logic [0:31] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[8*i +: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Row r of the column-major state rotates right by r columns.
  function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
    logic [0:127] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[8*(4*c+w) +: 8] = s[8*(4*((c - w + 4) % 4) + w) +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [0:127] inv_sub_bytes(input logic [0:127] s);
    logic [0:127] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    end
    return r;
  endfunction

  function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
    logic [0:127] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      r[32*c +: 32] = inv_mix_col(s[32*c +: 32]);
    end
    return r;
  endfunction

`ifdef AES_INV_KEY_LATCH_EN
  logic [0:1407] key_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q <= '0;
    end else if (state == IDLE && i_valid) begin
      key_q <= i_key_schedule;
    end
  end

  assign ks = key_q;
`else
  assign ks = i_key_schedule;
`endif

  always_comb begin
    rk = '0;
    for (int k = 0; k <= 10; k++) begin
      if (rnd == 4'(k)) rk = ks[128*k +: 128];
    end
  end

  // The final round shares the shift/sub/add path and simply skips the mix.
  assign add_rk  = inv_sub_bytes(inv_shift_rows(st)) ^ rk;
  assign mix_out = inv_mix_columns(add_rk);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid)     state_nxt = ROUND;
      ROUND:   if (rnd == 4'd0) state_nxt = DONE;
      DONE:    if (i_ready)     state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  assign o_ready = (state == IDLE);
  assign o_busy  = (state == ROUND) || (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rnd          <= 4'd0;
      st           <= '0;
      o_plain_text <= '0;
      o_valid      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            st  <= i_cipher_text ^ i_key_schedule[1280 +: 128];
            rnd <= 4'd9;
          end
        end
        ROUND: begin
          if (rnd != 4'd0) begin
            st  <= mix_out;
            rnd <= rnd - 4'd1;
          end else begin
            o_plain_text <= add_rk;
            o_valid      <= 1'b1;
          end
        end
        DONE: begin
          if (i_ready) o_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb/tb_aes_inv_cipher_iter.sv - self-checking bench for aes_inv_cipher_iter against an AES-128 model
module tb_aes_inv_cipher_iter;

  localparam logic [0:127] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] CT2 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [0:127] PT2 = 128'h6bc1bee22e409f96e93d7e117393172a;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic          o_ready;
  logic [0:127]  i_cipher_text;
  logic [0:1407] i_key_schedule;
  logic          o_valid;
  logic          i_ready;
  logic [0:127]  o_plain_text;
  logic          o_busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sbox_t [256];

  always #5 clk = ~clk;

  aes_inv_cipher_iter dut (
    .clk            (clk),
    .rst            (rst),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_cipher_text  (i_cipher_text),
    .i_key_schedule (i_key_schedule),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_plain_text   (o_plain_text),
    .o_busy         (o_busy)
  );

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return r;
  endfunction

  // S-box from first principles: multiplicative inverse then the affine map.
  task automatic build_tables;
    logic [7:0] b, s, xv, yv;
    for (int x = 0; x < 256; x++) begin
      xv = 8'(x);
      b  = 8'h00;
      for (int y = 1; y < 256; y++) begin
        yv = 8'(y);
        if (gf_mul(xv, yv) == 8'h01) b = yv;
      end
      s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [0:1407] key_expand(input logic [0:127] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [0:1407] ks;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 44; k++) ks[32*k +: 32] = w[k];
    return ks;
  endfunction

  function automatic logic [0:127] encrypt(input logic [0:127] pt, input logic [0:1407] ks);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [0:127] v;
    for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ ks[8*i +: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          t[4*c+w] = s[4*((c + w) % 4) + w];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
          s[4*c+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[128*r + 8*i +: 8];
    end
    for (int i = 0; i < 16; i++) v[8*i +: 8] = s[i];
    return v;
  endfunction

  // Present one block, count cycles from accept (cycle 0) to o_valid, stall, then take it.
  task automatic do_block(input logic [0:127] ct, input logic [0:1407] ks, input bit zero_key,
                          input int stall, output logic [0:127] pt, output int lat,
                          output bit stable);
    int n;
    pt     = '0;
    stable = 1'b1;
    n      = 0;
    @(negedge clk);
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    i_valid        = 1'b1;
    i_cipher_text  = ct;
    i_key_schedule = ks;
    @(negedge clk);
    i_valid = 1'b0;
    lat     = 1;
    if (zero_key) i_key_schedule = '0;
    while (!o_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    pt = o_plain_text;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (o_plain_text !== pt || o_valid !== 1'b1) stable = 1'b0;
    end
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_o_ready: got %b expected 1", o_ready); end
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid: got %b expected 0", o_valid); end
    checks++;
    if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_o_busy: got %b expected 0", o_busy); end
    checks++;
    if (o_plain_text !== 128'h0) begin failures++; $display("FAIL reset_plain: got %h expected 0", o_plain_text); end
    rst = 1'b0;
  endtask

  task automatic test_fips;
    logic [0:127] pt;
    int lat;
    bit stable;
    do_block(CT1, key_expand(K1), 1'b0, 3, pt, lat, stable);
    checks++;
    if (pt !== PT1) begin failures++; $display("FAIL fips_plain: got %h expected %h", pt, PT1); end
    checks++;
    if (lat != 11) begin failures++; $display("FAIL fips_latency: got %0d expected 11", lat); end
    checks++;
    if (!stable) begin failures++; $display("FAIL fips_stall_stable: got unstable expected stable"); end
  endtask

  task automatic test_backpressure;
    logic [0:127] pt;
    int n;
    @(negedge clk);
    i_valid        = 1'b1;
    i_cipher_text  = CT1;
    i_key_schedule = key_expand(K1);
    @(negedge clk);
    i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (o_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_timeout: got %b expected 1", o_valid); end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (o_plain_text !== PT1 || o_valid !== 1'b1 || o_ready !== 1'b0 || o_busy !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got pt=%h v=%b rdy=%b busy=%b expected pt=%h v=1 rdy=0 busy=1",
                 i, o_plain_text, o_valid, o_ready, o_busy, PT1);
      end
      i_valid       = (i % 3 == 0);
      i_cipher_text = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    i_valid       = 1'b1;
    i_cipher_text = CT1;
    i_ready       = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: got v=%b rdy=%b busy=%b expected v=0 rdy=1 busy=0", o_valid, o_ready, o_busy);
    end
    @(negedge clk);
    i_valid = 1'b0;
    checks++;
    if (o_busy !== 1'b1) begin failures++; $display("FAIL bp_accept_after_release: got busy=%b expected 1", o_busy); end
    n = 0;
    while (!o_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    pt = o_plain_text;
    checks++;
    if (pt !== PT1 || n != 10) begin
      failures++;
      $display("FAIL bp_second_block: got pt=%h wait=%0d expected pt=%h wait=10", pt, n, PT1);
    end
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [0:1407] ks1, ks2;
    logic [0:127]  outs [$];
    int            acc [$];
    int            first_valid;
    bit            switched;
    ks1 = key_expand(K1);
    ks2 = key_expand(K2);
    @(negedge clk);
    i_ready        = 1'b1;
    i_valid        = 1'b1;
    i_cipher_text  = CT1;
    i_key_schedule = ks1;
    switched       = 1'b0;
    first_valid    = -1;
    for (int cyc = 0; cyc < 40 && outs.size() < 2; cyc++) begin
      if (acc.size() >= 2) i_valid = 1'b0;
      if (i_valid && o_ready) acc.push_back(cyc);
      if (o_valid) begin
        outs.push_back(o_plain_text);
        if (first_valid < 0) first_valid = cyc;
        if (!switched) begin
          i_cipher_text  = CT2;
          i_key_schedule = ks2;
          switched       = 1'b1;
        end
      end
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_ready = 1'b0;
    checks++;
    if (acc.size() != 2 || outs.size() != 2) begin
      failures++;
      $display("FAIL b2b_counts: got accepts=%0d outputs=%0d expected 2 and 2", acc.size(), outs.size());
    end else begin
      checks++;
      if (outs[0] !== PT1) begin failures++; $display("FAIL b2b_plain1: got %h expected %h", outs[0], PT1); end
      checks++;
      if (outs[1] !== PT2) begin failures++; $display("FAIL b2b_plain2: got %h expected %h", outs[1], PT2); end
      checks++;
      if (acc[1] - acc[0] != 12) begin
        failures++;
        $display("FAIL b2b_period: got %0d expected 12", acc[1] - acc[0]);
      end
      checks++;
      if (first_valid - acc[0] != 11) begin
        failures++;
        $display("FAIL b2b_latency: got %0d expected 11", first_valid - acc[0]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [0:127] pt;
    int lat, seen;
    bit stable;
    @(negedge clk);
    i_valid        = 1'b1;
    i_cipher_text  = CT1;
    i_key_schedule = key_expand(K1);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (o_busy !== 1'b1) begin failures++; $display("FAIL rmid_busy_before: got %b expected 1", o_busy); end
    rst = 1'b1;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_ready !== 1'b1) begin
      failures++;
      $display("FAIL rmid_async: got busy=%b v=%b rdy=%b expected 0 0 1", o_busy, o_valid, o_ready);
    end
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (o_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL rmid_no_valid: got %0d valid cycles expected 0", seen); end
    checks++;
    if (o_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready: got %b expected 1", o_ready); end
    do_block(CT1, key_expand(K1), 1'b0, 0, pt, lat, stable);
    checks++;
    if (pt !== PT1 || lat != 11) begin
      failures++;
      $display("FAIL rmid_next_block: got pt=%h lat=%0d expected pt=%h lat=11", pt, lat, PT1);
    end
  endtask

`ifdef AES_INV_KEY_LATCH_EN
  task automatic test_key_latch;
    logic [0:127] pt;
    int lat;
    bit stable;
    do_block(CT1, key_expand(K1), 1'b1, 0, pt, lat, stable);
    checks++;
    if (pt !== PT1 || lat != 11) begin
      failures++;
      $display("FAIL key_latch: got pt=%h lat=%0d expected pt=%h lat=11", pt, lat, PT1);
    end
  endtask
`endif

  task automatic test_round_trip;
    logic [0:127]  key, pt, ct, got;
    logic [0:1407] ks;
    int lat, stall;
    bit stable;
    for (int n = 0; n < 1000; n++) begin
      key   = {$urandom, $urandom, $urandom, $urandom};
      pt    = {$urandom, $urandom, $urandom, $urandom};
      ks    = key_expand(key);
      ct    = encrypt(pt, ks);
      stall = int'($urandom_range(0, 3));
      do_block(ct, ks, 1'b0, stall, got, lat, stable);
      checks++;
      if (got !== pt || lat != 11 || !stable) begin
        failures++;
        $display("FAIL round_trip[%0d]: got pt=%h lat=%0d stable=%b expected pt=%h lat=11 stable=1",
                 n, got, lat, stable, pt);
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    i_valid        = 1'b0;
    i_ready        = 1'b0;
    i_cipher_text  = '0;
    i_key_schedule = '0;
    build_tables();
    test_reset();
    test_fips();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef AES_INV_KEY_LATCH_EN
    test_key_latch();
`endif
    test_round_trip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_inv_cipher_iter.md
# aes_inv_cipher_iter

Iterative AES-128 inverse cipher (decryption) core that consumes the same 11-round-key schedule format the encrypt pipeline stages carry. It performs one inverse round per clock under a valid/ready handshake. It sits at the receive end of the datapath, next to the key-expansion block, and serves block-level decryption and known-answer self-check of the encrypt pipeline.

## Interface
Parameters: none. Bit numbering is big-endian throughout: bit 0 is the MSB of byte 0.
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- i_valid  input  1  ciphertext block and key schedule presented
- o_ready  output  1  core can accept a block (high only in IDLE)
- i_cipher_text  input  [0:127]  ciphertext block
- i_key_schedule  input  [0:1407]  round key k occupies bits [128k : 128k+127], k = 0..10; k = 0 is the cipher key
- o_valid  output  1  o_plain_text holds a finished block
- i_ready  input  1  downstream accepts o_plain_text
- o_plain_text  output  [0:127]  decrypted block, registered
- o_busy  output  1  high in ROUND or DONE

## Operation
- State register: IDLE, ROUND, DONE.
- Round counter `rnd`: 4 bits.
- Working register `st`: 128 bits.
- **IDLE**
  - o_ready = 1.
  - On i_valid && o_ready: st <= i_cipher_text ^ rk10, rnd <= 9, go to ROUND.
- **ROUND, rnd ≥ 1**
  - st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk[rnd]).
  - rnd <= rnd - 1.
- **ROUND, rnd = 0 (final round)**
  - o_plain_text <= InvSubBytes(InvShiftRows(st)) ^ rk0.
  - o_valid <= 1, go to DONE.
- **DONE**
  - o_valid and o_plain_text are held stable until i_ready.
  - On i_ready: o_valid <= 0, go to IDLE.
  - o_ready stays low in the DONE-exit cycle. There is no same-cycle re-accept.
- i_valid while not in IDLE is ignored. No input is queued.
- i_ready while o_valid = 0 is ignored.
- InvSubBytes uses the FIPS-197 inverse S-box as a 256-entry function, instantiated 16 times.
- InvMixColumns uses GF(2^8) multiply by {0e, 0b, 0d, 09}, with reduction polynomial 0x11b.
- State byte order is column-major per FIPS-197: byte i = bits [8i : 8i+7], column c = bytes 4c..4c+3.

## Timing
- Reset values: state = IDLE, rnd = 0, st = 0, o_plain_text = 0, o_valid = 0, o_busy = 0, o_ready = 1.
- Latency: accept at cycle 0, rounds at cycles 1..10, o_valid high from cycle 11.
- Minimum period: 12 cycles per block when i_ready is tied high (accept 0, rounds 1–10, DONE 11, re-accept 12).
- o_ready and o_busy are decoded combinationally from the state register. All other outputs are registered.
- Reset asserted mid-operation (ROUND or DONE): everything returns to reset values immediately. The in-flight block is discarded and no o_valid pulse is produced.
- Downstream stall: DONE may hold indefinitely. o_plain_text must not change while o_valid = 1 && i_ready = 0.

## Configuration
- Macro: AES_INV_KEY_LATCH_EN.
- Defined:
  - The full 1408-bit i_key_schedule is captured into an internal register on accept.
  - Rounds use the captured copy, so the source may change right after the handshake.
- Undefined:
  - No key register is built. Rounds read i_key_schedule directly.
  - The source must hold i_key_schedule stable from accept through the final-round cycle (cycle 10).
  - Violating this is a protocol error with undefined output.

## Test plan
- **FIPS-197 C.1 vector.**
  - Stimulus: schedule expanded from key 000102030405060708090a0b0c0d0e0f (rk10 = 13111d7fe3944a17f307a78b4d2b30c5), ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: o_plain_text = 00112233445566778899aabbccddeeff, with o_valid rising exactly 11 cycles after accept.
- **Backpressure.**
  - Stimulus: hold i_ready = 0 for 20 cycles after o_valid rises, with i_valid pulsed during the hold.
  - Response: output stable, o_ready = 0 throughout, and the block is accepted only after i_ready.
- **Back-to-back.**
  - Stimulus: i_valid and i_ready held high, FIPS-197 C.1 followed by a second block 3ad77bb40d7a3660a89ecaf32466ef97 under key 2b7e151628aed2a6abf7158809cf4f3c.
  - Response: 6bc1bee22e409f96e93d7e117393172a, with accepts 12 cycles apart.
- **Reset mid-round.**
  - Stimulus: assert rst at cycle 5 after an accept.
  - Response: o_valid stays 0, o_ready = 1 after release, and the next C.1 block decrypts correctly.
- **Key latch (AES_INV_KEY_LATCH_EN defined).**
  - Stimulus: drive i_key_schedule to all-zero one cycle after accepting the C.1 vector.
  - Response: correct plaintext.
  - With the macro undefined, the bench skips this case.
- **Round trip.**
  - Stimulus: 1000 random keys and blocks, each encrypted by the encrypt pipeline model and then fed in.
  - Response: every output equals the original plaintext.
